instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch front end: owns the program counter, issues sequential reads to the
//  synchronous instruction memory and buffers returned words in a small queue. Presents
//  {instr, pc, pc+4} to the control/decode stage over a valid/ready handshake.
//  Accepts branch/jump redirects from downstream, which flush everything queued or in flight.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset; bits [1:0] must be 0
//  QDEPTH    2              instruction queue entries; 2..8; >=2 required for 1 instr/cycle
// PORTS
//  clk          in   1   clock, all state updates on posedge
//  clr_n        in   1   synchronous active-low reset
//  imem_req     out  1   read request this cycle
//  imem_addr    out  32  word-aligned read address, valid when imem_req=1
//  imem_rdata   in   32  read data, valid exactly 1 cycle after imem_req
//  redirect     in   1   branch/jump taken; overrides all other activity this cycle
//  redirect_pc  in   32  new fetch address; bits [1:0] ignored (forced 0)
//  out_valid    out  1   queue head valid
//  out_ready    in   1   consumer accepts head this cycle
//  out_instr    out  32  head instruction word
//  out_pc       out  32  address of out_instr
//  out_pc4      out  32  out_pc + 4 (mod 2^32)
// BEHAVIOUR
//  Reset (clr_n=0 at posedge): pc<=RESET_PC, queue count<=0, inflight<=0, kill<=0;
//   outputs next cycle: imem_req=0, out_valid=0, out_instr/out_pc/out_pc4=0.
//  Issue: imem_req = clr_n & ~redirect & (count + inflight - pop < QDEPTH); imem_addr=pc.
//   On issue pc<=pc+4, 32-bit wrap (32'hFFFF_FFFC -> 0). inflight<=imem_req.
//  Return: in the cycle after an issue, imem_rdata with its address is pushed to the
//   queue tail unless kill=1 or redirect=1 in that cycle (word dropped).
//  Pop: out_valid & out_ready; head advances. Push+pop same cycle legal, count unchanged.
//   Credit rule (count+inflight<=QDEPTH) guarantees no overflow; push never stalls.
//  Redirect (highest priority): count<=0 (out_valid=0 next cycle), pc<=redirect_pc&~3,
//   kill<=inflight (response of the request issued this or previous cycle is dropped),
//   no issue this cycle, any pop this cycle is ignored. Next cycle issues redirect_pc.
//  Redirect in the cycle after a redirect: second one wins; prior target is never pushed.
//  Latency: issue cycle N -> pushed at end of N+1 -> out_valid in N+2. Redirect to first
//   valid: 3 cycles. Steady state with out_ready=1 and QDEPTH>=2: one instr per cycle.
//  out_ready=0: queue fills to QDEPTH then imem_req deasserts; resumes the cycle a pop
//   frees a credit. Outputs stable while out_valid & ~out_ready.
//  Reset asserted mid-operation discards queue and in-flight read; no push after reset.
//  Instruction content not interpreted (no predecode); illegal opcodes pass through.
// STRUCTURE
//  Shared include cpu_defs.v: `INSTR_W 32, `ADDR_W 32, `RESET_VECTOR, `NOP_INSTR 32'h0.
//  Sub-module fetch_queue: parameterised circular FIFO, push/pop/flush, count output,
//   head data {instr, pc}; flush has priority over push and pop.
//  Top holds pc, inflight, kill flags and issue/credit logic; out_pc4 is combinational.
// TESTING
//  Reset release, RESET_PC=0, out_ready=1, imem returns mem[addr>>2] -> imem_addr 0,4,8..
//   on consecutive cycles; out_valid first at cycle 2 with out_pc=0, then 1 instr/cycle.
//  out_ready=0 for 10 cycles -> exactly QDEPTH entries held, imem_req=0 after 2 issues,
//   no duplicate or lost pc when out_ready returns high (sequence 0,4,8,... intact).
//  redirect=1 redirect_pc=32'h0000_0103 while queue full and read in flight -> next
//   out_valid shows out_pc=32'h100, 3 cycles later; no word from old stream appears.
//  Back-to-back redirects to 0x200 then 0x300 -> first delivered out_pc=0x300; 0x200 never seen.
//  pc near wrap: redirect to 32'hFFFF_FFF8 -> out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000;
//   out_pc4 of FFFF_FFFC = 0.
//  clr_n=0 for 1 cycle mid-stream with out_ready=0 -> out_valid=0 next cycle, fetch
//   restarts at RESET_PC, stale in-flight data never delivered.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared types and constants for the instruction fetch front end
package instr_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular FIFO holding fetched {instr, pc} entries
module fetch_queue #(
    parameter  int DEPTH = 2,
    parameter  int W     = 64,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head_data,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign do_pop    = pop && (count != '0);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!clr_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)
                rd_ptr <= ptr_inc(rd_ptr);
            unique case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (clr_n && !flush && push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC owner, credit-based imem issue and redirect handling
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        clr_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam int SW = $clog2(QDEPTH + 2);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] ret_pc;
    logic              inflight;
    logic              kill;
    logic [CW-1:0]     count;
    logic              push;
    logic              pop;
    logic [SW-1:0]     occupancy;
    logic [SW-1:0]     credit_limit;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    assign out_valid    = (count != '0);
    assign pop          = out_valid & out_ready & ~redirect;
    // A pop this cycle frees a slot early enough for a same-cycle issue.
    assign occupancy    = SW'(count) + SW'(inflight);
    assign credit_limit = SW'(QDEPTH) + SW'(pop);
    assign imem_req     = clr_n & ~redirect & (occupancy < credit_limit);
    assign imem_addr    = pc;

    assign push             = inflight & ~kill & ~redirect;
    assign push_entry.instr = imem_rdata;
    assign push_entry.pc    = ret_pc;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            pc       <= RESET_PC;
            ret_pc   <= '0;
            inflight <= 1'b0;
            kill     <= 1'b0;
        end else begin
            inflight <= imem_req;
            kill     <= redirect & inflight;
            if (redirect) begin
                pc <= word_align(redirect_pc);
            end else if (imem_req) begin
                pc     <= pc + 32'd4;
                ret_pc <= pc;
            end
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH),
        .W     (ENTRY_W)
    ) u_queue (
        .clk       (clk),
        .clr_n     (clr_n),
        .flush     (redirect),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head),
        .count     (count)
    );

    assign out_instr = out_valid ? head.instr : NOP_INSTR;
    assign out_pc    = out_valid ? head.pc : '0;
    assign out_pc4   = out_valid ? head.pc + 32'd4 : '0;

endmodule
